rf_read_port_arbiter: RTL and testbench
=======================================

# rf_read_port_arbiter

Shares the register file's two synchronous read ports among NUM_REQ operand requesters in the decode stage. Each cycle it grants up to two requests in round-robin order and drives the per-port read enables and selects. It returns each requester's read data, tagged with a per-requester valid, one cycle later. It sits between the decode-stage operand-fetch logic and the register file read-enable/select inputs.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters; legal range 2..8.
- ADDR_W, 2: register select width.
- DATA_W, 16: register data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush: blocks new grants and suppresses the response in the current cycle.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_W  register select; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  combinational grant; a handshake completes when req_valid[i] & req_ready[i] at a rising edge.
- rf_re_1, rf_re_2  out  1  register file read-port enables.
- rf_re_1_sel, rf_re_2_sel  out  ADDR_W  read-port selects; 0 when the port's enable is low.
- rf_rd_data_1, rf_rd_data_2  in  DATA_W  register file read data, valid the cycle after the enable.
- rsp_valid  out  NUM_REQ  response valid, one per requester.
- rsp_data  out  NUM_REQ*DATA_W  response data; a requester's slice is 0 when its rsp_valid bit is low.

## Operation
- State:
  - rr_ptr, range 0..NUM_REQ-1: highest-priority requester.
  - port_map[i], 2 bits per requester: NONE=0, P1=1, P2=2.
- Arbitration (combinational):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - The first valid requester gets port 1; the next valid one gets port 2.
  - All other requesters see req_ready = 0.
- flush = 1: req_ready = 0 for all requesters, both rf_re = 0, rr_ptr holds.
- rr_ptr update: on any grant, rr_ptr becomes (scan position of the last port-owning requester) + 1, modulo NUM_REQ. With no grants, rr_ptr holds.
- port_map register: loads each requester's assigned port at every edge; requesters without a grant load NONE.
- Response (combinational from port_map):
  - rsp_valid[i] = (port_map[i] != NONE) & ~flush.
  - rsp_data[i] is taken from rf_rd_data_1 or rf_rd_data_2 according to port_map[i].
- Requesters may drop req_valid or change req_addr at any time before the handshake; the block keeps no request state.
- Responses cannot be stalled. Requesters must accept rsp_valid in the cycle it is asserted.

## Timing
- Grant in cycle T: rf_re_x and rf_re_x_sel are driven in cycle T, and the register file samples them at the end of T.
- Response appears in cycle T+1: rsp_valid and rsp_data. Latency is exactly one cycle; throughput is two reads per cycle.
- Reset (asynchronous, takes effect immediately):
  - rr_ptr = 0, all port_map = NONE, so rsp_valid = 0 and rsp_data = 0 immediately.
  - rf_re_1 = rf_re_2 = 0 and req_ready = 0 while rst_n is low.
- Reset mid-operation: an in-flight response is discarded and never re-issued.
- flush in cycle T+1 suppresses the cycle T+1 response. port_map still clears normally at the end of T+1.
- No requests: rf_re = 0, selects = 0, port_map loads NONE.
- A single valid request uses port 1 only.

## Configuration
- RF_READ_MERGE_EN defined:
  - After a port is assigned address A, every other valid requester in the scan whose req_addr equals A is also granted on that port.
  - Port 2 is given to the next requester whose address is distinct from the port-1 address; its own address matches merge onto port 2 the same way.
  - Merged requesters do not move rr_ptr.
- RF_READ_MERGE_EN undefined: at most two grants per cycle, and identical addresses occupy both ports.

## Structure
- Shared package rf_arb_pkg holds:
  - port id constants PORT_NONE, PORT_1, PORT_2;
  - default ADDR_W and DATA_W.
- Sub-module rr_priority_picker: rotated find-first-set over a NUM_REQ vector starting at a given pointer. It returns a one-hot vector and an index, and is instantiated twice (port 1, then port 2 with the first winner masked).

## Test plan
Configuration for all scenarios: NUM_REQ=3, ADDR_W=2, DATA_W=8.
1. Reset, then req_valid=001 with addr 2 -> rf_re_1=1, rf_re_1_sel=2, req_ready=001. Next cycle rf_rd_data_1=0x5A gives rsp_valid=001 and slice 0 = 0x5A.
2. rr_ptr=0, req_valid=111, addresses 0,1,3 -> req_ready=011 (req0 on port 1, req1 on port 2), rr_ptr becomes 2. Holding all three valid, the next cycle gives req_ready=101 with req2 on port 1.
3. req_valid=111, addresses 1,1,2 -> with RF_READ_MERGE_EN: req_ready=111, port-1 select 1, port-2 select 2. Without it: req_ready=011.
4. Grant req0 in cycle T, flush=1 in T+1 -> rsp_valid=000 in T+1 and req_ready=000 in T+1.
5. Grant in T, rst_n low mid-T+1 -> rsp_valid and rsp_data go to 0 immediately, and rf_re_1 = rf_re_2 = 0.
6. All three continuously valid with distinct addresses for 3 cycles -> each requester granted exactly twice, with no requester skipped two cycles in a row.

Source files
------------

// File: rtl/rf_read_port_arbiter_pkg.sv
// Shared definitions for the register-file read-port arbiter: port ids and default widths.
package rf_arb_pkg;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_1    = 2'd1,
    PORT_2    = 2'd2
  } port_id_e;

  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/rf_read_port_arbiter_picker.sv
// Rotated find-first-set: returns the first set bit of req scanning from ptr upward, modulo N.
module rr_priority_picker #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             found
);

  int pos;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos]) begin
        found         = 1'b1;
        grant_oh[pos] = 1'b1;
        grant_idx     = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/rf_read_port_arbiter.sv
// Round-robin arbiter sharing two synchronous register-file read ports among NUM_REQ requesters.
// Optional address merging onto an already-granted port is enabled by defining RF_READ_MERGE_EN.
module rf_read_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_re_1,
  output logic                      rf_re_2,
  output logic [ADDR_W-1:0]         rf_re_1_sel,
  output logic [ADDR_W-1:0]         rf_re_2_sel,
  input  logic [DATA_W-1:0]         rf_rd_data_1,
  input  logic [DATA_W-1:0]         rf_rd_data_2,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  port_id_e           port_map_reg [NUM_REQ];
  port_id_e           port_map_next [NUM_REQ];

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0] cand1, cand2;
  logic [NUM_REQ-1:0] oh1, oh2;
  logic [IDX_W-1:0]   idx1, idx2;
  logic               found1, found2;
  logic [ADDR_W-1:0]  sel1, sel2;
  logic [NUM_REQ-1:0] grant1, grant2;
  logic [IDX_W-1:0]   last_idx;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Reset and flush both suppress every grant, so they simply empty the candidate set.
  assign cand1 = req_valid & {NUM_REQ{rst_n & ~flush}};

  rr_priority_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_1 (
    .req       (cand1),
    .ptr       (rr_ptr_reg),
    .grant_oh  (oh1),
    .grant_idx (idx1),
    .found     (found1)
  );

  assign sel1 = addr_arr[idx1];

`ifdef RF_READ_MERGE_EN
  logic [NUM_REQ-1:0] match1, match2;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_match
      assign match1[gi] = (addr_arr[gi] == sel1);
      assign match2[gi] = (addr_arr[gi] == sel2);
    end
  endgenerate

  assign grant1 = cand1 & ({NUM_REQ{found1}} & match1 | oh1);
  assign cand2  = cand1 & ~match1;
  assign grant2 = cand2 & ({NUM_REQ{found2}} & match2 | oh2);
`else
  assign grant1 = oh1;
  assign cand2  = cand1 & ~oh1;
  assign grant2 = oh2;
`endif

  rr_priority_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_2 (
    .req       (cand2),
    .ptr       (rr_ptr_reg),
    .grant_oh  (oh2),
    .grant_idx (idx2),
    .found     (found2)
  );

  assign sel2        = addr_arr[idx2];
  assign req_ready   = grant1 | grant2;
  assign rf_re_1     = found1;
  assign rf_re_2     = found2;
  assign rf_re_1_sel = found1 ? sel1 : '0;
  assign rf_re_2_sel = found2 ? sel2 : '0;

  // Only the port owners advance the pointer; merged requesters ride along.
  assign last_idx = found2 ? idx2 : idx1;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (found1) begin
      rr_ptr_next = (last_idx == IDX_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port_map
      assign port_map_next[gi] = grant1[gi] ? PORT_1 :
                                 grant2[gi] ? PORT_2 : PORT_NONE;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          port_map_reg[gi] <= PORT_NONE;
        end else begin
          port_map_reg[gi] <= port_map_next[gi];
        end
      end

      assign rsp_valid[gi] = (port_map_reg[gi] != PORT_NONE) & ~flush;
      assign rsp_data[gi*DATA_W +: DATA_W] =
          !rsp_valid[gi]               ? '0 :
          (port_map_reg[gi] == PORT_1) ? rf_rd_data_1 : rf_rd_data_2;
    end
  endgenerate

endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// Randomized bench for rf_read_port_arbiter with an in-bench scan-list reference model
// and directed literal checks of the key arbitration scenarios.
module tb_rf_read_port_arbiter;

  localparam int NR = 3;
  localparam int AW = 2;
  localparam int DW = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic [NR-1:0]  req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0]  req_ready;
  logic           rf_re_1, rf_re_2;
  logic [AW-1:0]  rf_re_1_sel, rf_re_2_sel;
  logic [DW-1:0]  rf_rd_data_1 = '0, rf_rd_data_2 = '0;
  logic [NR-1:0]  rsp_valid;
  logic [NR*DW-1:0] rsp_data;

  int checks = 0;
  int errors = 0;

  rf_read_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .rf_re_1      (rf_re_1),
    .rf_re_2      (rf_re_2),
    .rf_re_1_sel  (rf_re_1_sel),
    .rf_re_2_sel  (rf_re_2_sel),
    .rf_rd_data_1 (rf_rd_data_1),
    .rf_rd_data_2 (rf_rd_data_2),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: build the list of valid requesters in scan order, then hand out ports.
  function automatic void model_eval(
    input int ptr, input logic [NR-1:0] v, input logic [NR*AW-1:0] a, input logic fl,
    output logic [NR-1:0] rdy, output logic re1, output logic [AW-1:0] s1,
    output logic re2, output logic [AW-1:0] s2, output logic [2*NR-1:0] mapn, output int nptr);
    int order[$];
    int p1, p2, last;
    rdy = '0; re1 = 0; s1 = '0; re2 = 0; s2 = '0; mapn = '0; nptr = ptr;
    for (int k = 0; k < NR; k++) begin
      int r;
      r = (ptr + k) % NR;
      if (v[r] && !fl) order.push_back(r);
    end
    if (order.size() == 0) return;
    p1 = order[0];
    re1 = 1; s1 = a[p1*AW +: AW]; mapn[p1*2 +: 2] = 2'd1; last = p1;
`ifdef RF_READ_MERGE_EN
    foreach (order[j]) if (a[order[j]*AW +: AW] == s1) mapn[order[j]*2 +: 2] = 2'd1;
    p2 = -1;
    foreach (order[j]) if (p2 < 0 && a[order[j]*AW +: AW] != s1) p2 = order[j];
    if (p2 >= 0) begin
      re2 = 1; s2 = a[p2*AW +: AW]; last = p2;
      foreach (order[j]) if (a[order[j]*AW +: AW] == s2) mapn[order[j]*2 +: 2] = 2'd2;
    end
`else
    if (order.size() > 1) begin
      p2 = order[1];
      re2 = 1; s2 = a[p2*AW +: AW]; mapn[p2*2 +: 2] = 2'd2; last = p2;
    end
`endif
    nptr = (last + 1) % NR;
    for (int i = 0; i < NR; i++) rdy[i] = (mapn[i*2 +: 2] != 2'd0);
  endfunction

  int               m_ptr;
  logic [2*NR-1:0]  m_map;
  logic [NR-1:0]    u_rdy;
  logic             u_re1, u_re2;
  logic [AW-1:0]    u_s1, u_s2;
  logic [2*NR-1:0]  u_map;
  int               u_ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0;
      m_map <= '0;
    end else begin
      model_eval(m_ptr, req_valid, req_addr, flush, u_rdy, u_re1, u_s1, u_re2, u_s2, u_map, u_ptr);
      m_ptr <= u_ptr;
      m_map <= u_map;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic [NR-1:0]   e_rdy, e_rv;
    logic            e_re1, e_re2;
    logic [AW-1:0]   e_s1, e_s2;
    logic [2*NR-1:0] e_map;
    logic [NR*DW-1:0] e_rd;
    int              e_ptr;
    if (rst_n) begin
      model_eval(m_ptr, req_valid, req_addr, flush, e_rdy, e_re1, e_s1, e_re2, e_s2, e_map, e_ptr);
    end else begin
      e_rdy = '0; e_re1 = 0; e_re2 = 0; e_s1 = '0; e_s2 = '0;
    end
    e_rv = '0; e_rd = '0;
    for (int i = 0; i < NR; i++) begin
      if (m_map[i*2 +: 2] != 2'd0 && !flush) begin
        e_rv[i] = 1'b1;
        e_rd[i*DW +: DW] = (m_map[i*2 +: 2] == 2'd1) ? rf_rd_data_1 : rf_rd_data_2;
      end
    end
    chk("model_req_ready", 32'(req_ready), 32'(e_rdy));
    chk("model_port1", {rf_re_1, 30'(rf_re_1_sel)}, {e_re1, 30'(e_s1)});
    chk("model_port2", {rf_re_2, 30'(rf_re_2_sel)}, {e_re2, 30'(e_s2)});
    chk("model_rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("model_rsp_data", 32'(rsp_data), 32'(e_rd));
  end

  task automatic drive(input logic [NR-1:0] v, input logic [NR*AW-1:0] a, input logic fl,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    @(posedge clk);
    #1;
    req_valid = v; req_addr = a; flush = fl; rf_rd_data_1 = d1; rf_rd_data_2 = d2;
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    req_valid = '0; flush = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  int grant_cnt [NR];
  int idle_run  [NR];
  int max_idle;

  initial begin
    do_reset();

    // 1: single request on port 1, response one cycle later
    drive(3'b001, {2'd0, 2'd0, 2'd2}, 0, 8'h00, 8'h00);
    chk("t1_ready", 32'(req_ready), 32'b001);
    chk("t1_re1_sel", {rf_re_1, 30'(rf_re_1_sel)}, {1'b1, 30'd2});
    chk("t1_re2", 32'(rf_re_2), 32'd0);
    drive(3'b000, '0, 0, 8'h5A, 8'h11);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'b001);
    chk("t1_rsp_data0", 32'(rsp_data[7:0]), 32'h5A);

    // 2: round-robin pointer advance
    do_reset();
    drive(3'b111, {2'd3, 2'd1, 2'd0}, 0, 8'h00, 8'h00);
    chk("t2_ready_a", 32'(req_ready), 32'b011);
    chk("t2_sel_a", {30'(rf_re_1_sel), 2'(rf_re_2_sel)}, {30'd0, 2'd1});
    drive(3'b111, {2'd3, 2'd1, 2'd0}, 0, 8'h00, 8'h00);
    chk("t2_ready_b", 32'(req_ready), 32'b101);
    chk("t2_sel1_b", 32'(rf_re_1_sel), 32'd3);

    // 3: identical addresses
    do_reset();
    drive(3'b111, {2'd2, 2'd1, 2'd1}, 0, 8'h00, 8'h00);
`ifdef RF_READ_MERGE_EN
    chk("t3_ready", 32'(req_ready), 32'b111);
    chk("t3_sels", {30'(rf_re_1_sel), 2'(rf_re_2_sel)}, {30'd1, 2'd2});
`else
    chk("t3_ready", 32'(req_ready), 32'b011);
    chk("t3_sels", {30'(rf_re_1_sel), 2'(rf_re_2_sel)}, {30'd1, 2'd1});
`endif

    // 4: flush suppresses response and grants
    do_reset();
    drive(3'b001, '0, 0, 8'h00, 8'h00);
    drive(3'b111, '0, 1, 8'h77, 8'h66);
    chk("t4_rsp_valid", 32'(rsp_valid), 32'b000);
    chk("t4_ready", 32'(req_ready), 32'b000);
    chk("t4_re", {rf_re_1, rf_re_2}, 2'b00);

    // 5: reset mid-cycle discards the in-flight response immediately
    drive(3'b001, '0, 0, 8'h00, 8'h00);
    drive(3'b001, '0, 0, 8'hC3, 8'h3C);
    chk("t5_pre_rsp", 32'(rsp_valid), 32'b001);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'b000);
    chk("t5_rsp_data", 32'(rsp_data), 32'd0);
    chk("t5_re", {rf_re_1, rf_re_2}, 2'b00);
    chk("t5_ready", 32'(req_ready), 32'b000);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // 6: fairness over three cycles with all requesters valid
    foreach (grant_cnt[i]) begin grant_cnt[i] = 0; idle_run[i] = 0; end
    max_idle = 0;
    for (int c = 0; c < 3; c++) begin
      drive(3'b111, {2'd3, 2'd1, 2'd0}, 0, 8'h00, 8'h00);
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) begin grant_cnt[i]++; idle_run[i] = 0; end
        else begin idle_run[i]++; if (idle_run[i] > max_idle) max_idle = idle_run[i]; end
      end
    end
    for (int i = 0; i < NR; i++) chk($sformatf("t6_grants_req%0d", i), 32'(grant_cnt[i]), 32'd2);
    chk("t6_max_skip", 32'(max_idle), 32'd1);

    // Randomized traffic, with occasional flushes and resets
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        drive(NR'($urandom), (NR*AW)'($urandom), ($urandom_range(0, 7) == 0),
              DW'($urandom), DW'($urandom));
      end
    end

    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
